// File: rtl/branch_predict_table_if.sv
// Lookup, update, flush and statistics signals of the branch prediction table.
// The master drives fetch/resolve traffic; the slave is the table itself.
interface branch_predict_table_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 16
);
  logic              lookup_valid_i;
  logic [ADDR_W-1:0] lookup_pc_i;
  logic [31:0]       lookup_inst_i;
  logic              hold_i;
  logic              update_valid_i;
  logic [ADDR_W-1:0] update_pc_i;
  logic              update_taken_i;
  logic              update_mispredict_i;
  logic              flush_i;
  logic              predict_hit_o;
  logic              predict_taken_o;
  logic [ADDR_W-1:0] predict_target_o;
  logic [STAT_W-1:0] lookup_cnt_o;
  logic [STAT_W-1:0] mispredict_cnt_o;

  // A qualifier (lookup_valid_i / update_valid_i) marks its payload meaningful in
  // that cycle only; there is no backpressure, and predictions are combinational.
  modport master (
    output lookup_valid_i, lookup_pc_i, lookup_inst_i, hold_i,
    output update_valid_i, update_pc_i, update_taken_i, update_mispredict_i, flush_i,
    input  predict_hit_o, predict_taken_o, predict_target_o, lookup_cnt_o, mispredict_cnt_o
  );

  modport slave (
    input  lookup_valid_i, lookup_pc_i, lookup_inst_i, hold_i,
    input  update_valid_i, update_pc_i, update_taken_i, update_mispredict_i, flush_i,
    output predict_hit_o, predict_taken_o, predict_target_o, lookup_cnt_o, mispredict_cnt_o
  );
endinterface

// File: rtl/branch_predict_table.sv
// Fully associative branch direction table with saturating counters, static
// backward-taken fallback on a miss, and lookup/mispredict statistics.
module branch_predict_table #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 4,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_table_if.slave bus
);
  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]  tag_q [ENTRIES];
  logic [ADDR_W-1:0]  tag_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_d [ENTRIES];
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [STAT_W-1:0]  lcnt_q, lcnt_d, mcnt_q, mcnt_d;

  logic              is_branch;
  logic [12:0]       imm13;
  logic [ADDR_W-1:0] imm_b;
  logic              lk_hit, up_hit, free_found;
  logic [IDX_W-1:0]  lk_idx, up_idx, free_idx, victim;
  logic              lookup_br, alloc_en, upd_en;

  always_comb begin
    is_branch = (bus.lookup_inst_i[6:0] == 7'b1100011);
    imm13     = {bus.lookup_inst_i[31], bus.lookup_inst_i[7], bus.lookup_inst_i[30:25],
                 bus.lookup_inst_i[11:8], 1'b0};
    imm_b     = {{(ADDR_W-13){imm13[12]}}, imm13};
  end

  // Tags are unique (allocation only on a miss), so the last match is the only one.
  always_comb begin
    lk_hit     = 1'b0;
    lk_idx     = '0;
    up_hit     = 1'b0;
    up_idx     = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == bus.lookup_pc_i) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (valid_q[i] && tag_q[i] == bus.update_pc_i) begin
        up_hit = 1'b1;
        up_idx = IDX_W'(i);
      end
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    victim    = free_found ? free_idx : ptr_q;
    lookup_br = bus.lookup_valid_i & is_branch & ~bus.flush_i;
    alloc_en  = lookup_br & ~lk_hit & ~bus.hold_i;
    upd_en    = bus.update_valid_i & ~bus.flush_i & up_hit;
  end

  assign bus.predict_target_o = bus.lookup_pc_i + imm_b;
  assign bus.predict_hit_o    = lookup_br & lk_hit;
  assign bus.predict_taken_o  = lookup_br & (lk_hit ? ctr_q[lk_idx][CTR_W-1] : imm_b[ADDR_W-1]);
  assign bus.lookup_cnt_o     = lcnt_q;
  assign bus.mispredict_cnt_o = mcnt_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    ctr_d   = ctr_q;
    ptr_d   = ptr_q;
    lcnt_d  = lcnt_q;
    mcnt_d  = mcnt_q;
    if (bus.flush_i) begin
      valid_d = '0;
      ptr_d   = '0;
    end else begin
      // A same-cycle allocation into the updated entry discards the update.
      if (upd_en && !(alloc_en && victim == up_idx)) begin
        if (bus.update_taken_i && ctr_q[up_idx] != '1)
          ctr_d[up_idx] = ctr_q[up_idx] + CTR_W'(1);
        else if (!bus.update_taken_i && ctr_q[up_idx] != '0)
          ctr_d[up_idx] = ctr_q[up_idx] - CTR_W'(1);
      end
      if (alloc_en) begin
        valid_d[victim] = 1'b1;
        tag_d[victim]   = bus.lookup_pc_i;
        ctr_d[victim]   = imm_b[ADDR_W-1] ? CTR_WEAK_T : CTR_WEAK_NT;
        if (!free_found) ptr_d = ptr_q + IDX_W'(1);
      end
    end
    if (lookup_br && !bus.hold_i && lcnt_q != '1) lcnt_d = lcnt_q + STAT_W'(1);
    if (bus.update_valid_i && bus.update_mispredict_i && !bus.flush_i && mcnt_q != '1)
      mcnt_d = mcnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= CTR_WEAK_NT;
      end
      ptr_q  <= '0;
      lcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      ctr_q   <= ctr_d;
      ptr_q   <= ptr_d;
      lcnt_q  <= lcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predict_table.sv
// Bench for branch_predict_table: a 16-bit-statistics instance and a 2-bit one
// share stimulus; a table-level reference model feeds an expected-value queue.
module tb_branch_predict_table;
  localparam int EW = 70;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predict_table_if #(.ADDR_W(32), .STAT_W(16)) bus ();
  branch_predict_table_if #(.ADDR_W(32), .STAT_W(2))  bus_s ();

  branch_predict_table #(.ADDR_W(32), .ENTRIES(4), .CTR_W(2), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  branch_predict_table #(.ADDR_W(32), .ENTRIES(4), .CTR_W(2), .STAT_W(2)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s));

  assign bus_s.lookup_valid_i      = bus.lookup_valid_i;
  assign bus_s.lookup_pc_i         = bus.lookup_pc_i;
  assign bus_s.lookup_inst_i       = bus.lookup_inst_i;
  assign bus_s.hold_i              = bus.hold_i;
  assign bus_s.update_valid_i      = bus.update_valid_i;
  assign bus_s.update_pc_i         = bus.update_pc_i;
  assign bus_s.update_taken_i      = bus.update_taken_i;
  assign bus_s.update_mispredict_i = bus.update_mispredict_i;
  assign bus_s.flush_i             = bus.flush_i;

  // Reference model: a 4-entry table of {valid, pc, counter 0..3}
  bit          m_valid [4];
  logic [31:0] m_tag   [4];
  int          m_ctr   [4];
  int          m_ptr, m_lcnt, m_mcnt, s_lcnt, s_mcnt;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] make_inst(input int imm, input bit br);
    logic [12:0] b;
    logic [4:0]  rs1, rs2;
    b   = imm[12:0];
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    return {b[12], b[10:5], rs2, rs1, 3'b000, b[4:1], b[11], (br ? 7'b1100011 : 7'b0110011)};
  endfunction

  // One cycle of stimulus: drive, predict outputs from pre-edge model, advance model.
  task automatic cyc(input bit lv, input logic [31:0] pc, input int imm, input bit br,
                     input bit hold, input bit uv, input logic [31:0] upc, input bit ut,
                     input bit um, input bit flush, input bit r);
    bit hit, uhit, e_hit, e_taken, lk;
    int idx, uidx, v;
    logic [31:0] tgt;
    rst                     = r;
    bus.lookup_valid_i      = lv;
    bus.lookup_pc_i         = pc;
    bus.lookup_inst_i       = make_inst(imm, br);
    bus.hold_i              = hold;
    bus.update_valid_i      = uv;
    bus.update_pc_i         = upc;
    bus.update_taken_i      = ut;
    bus.update_mispredict_i = um;
    bus.flush_i             = flush;

    hit = 0; idx = 0; uhit = 0; uidx = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && m_tag[i] == pc) begin hit = 1; idx = i; end
      if (m_valid[i] && m_tag[i] == upc) begin uhit = 1; uidx = i; end
    end
    lk      = lv && br && !flush;
    e_hit   = lk && hit;
    e_taken = lk && (hit ? (m_ctr[idx] >= 2) : (imm < 0));
    tgt     = pc + 32'(imm);
    if (!r)
      exp_q.push_back({e_hit, e_taken, tgt, 16'(m_lcnt), 16'(m_mcnt), 2'(s_lcnt), 2'(s_mcnt)});

    if (r) begin
      for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_tag[i] = '0; m_ctr[i] = 1; end
      m_ptr = 0; m_lcnt = 0; m_mcnt = 0; s_lcnt = 0; s_mcnt = 0;
    end else begin
      if (flush) begin
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
        m_ptr = 0;
      end else begin
        if (uv && uhit) m_ctr[uidx] = ut ? ((m_ctr[uidx] < 3) ? m_ctr[uidx] + 1 : 3)
                                         : ((m_ctr[uidx] > 0) ? m_ctr[uidx] - 1 : 0);
        if (lk && !hit && !hold) begin
          v = -1;
          for (int i = 3; i >= 0; i--) if (!m_valid[i]) v = i;
          if (v < 0) begin v = m_ptr; m_ptr = (m_ptr + 1) % 4; end
          m_valid[v] = 1; m_tag[v] = pc; m_ctr[v] = (imm < 0) ? 2 : 1;
        end
      end
      if (lk && !hold) begin
        if (m_lcnt < 65535) m_lcnt++;
        if (s_lcnt < 3) s_lcnt++;
      end
      if (uv && um && !flush) begin
        if (m_mcnt < 65535) m_mcnt++;
        if (s_mcnt < 3) s_mcnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input int imm, input bit hold);
    cyc(1, pc, imm, 1, hold, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] upc, input bit ut, input bit um);
    cyc(0, 32'h0, 0, 0, 0, 1, upc, ut, um, 0, 0);
  endtask

  task automatic do_reset();
    cyc(0, '0, 0, 0, 0, 0, '0, 0, 0, 0, 1);
    cyc(0, '0, 0, 0, 0, 0, '0, 0, 0, 0, 1);
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle against the queue head.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      chk("hit",       64'(bus.predict_hit_o),      64'(e[69]));
      chk("taken",     64'(bus.predict_taken_o),    64'(e[68]));
      chk("target",    64'(bus.predict_target_o),   64'(e[67:36]));
      chk("lookup_cnt", 64'(bus.lookup_cnt_o),      64'(e[35:20]));
      chk("mispred_cnt", 64'(bus.mispredict_cnt_o), 64'(e[19:4]));
      chk("hit_s",     64'(bus_s.predict_hit_o),    64'(e[69]));
      chk("taken_s",   64'(bus_s.predict_taken_o),  64'(e[68]));
      chk("lookup_cnt_s", 64'(bus_s.lookup_cnt_o),  64'(e[3:2]));
      chk("mispred_cnt_s", 64'(bus_s.mispredict_cnt_o), 64'(e[1:0]));
    end
  end

  logic [31:0] pool [12];

  initial begin
    for (int k = 0; k < 12; k++) pool[k] = 32'h1000 + 32'(k * 16);
    @(posedge clk);
    #1;
    do_reset();
    cyc(0, 32'h40, 8, 0, 0, 0, '0, 0, 0, 0, 0);

    // Backward BEQ: static taken on miss, then hit
    look(32'h100, -8, 0);
    look(32'h100, -8, 0);

    // Forward branch, counter walk up to saturation and back down
    look(32'h200, 16, 0);
    look(32'h200, 16, 0);
    upd(32'h200, 1, 0);
    look(32'h200, 16, 1);
    upd(32'h200, 1, 0);
    look(32'h200, 16, 1);
    for (int k = 0; k < 4; k++) upd(32'h200, 0, 0);
    look(32'h200, 16, 1);

    // Five distinct branches into four entries: round-robin replacement
    do_reset();
    for (int k = 0; k < 5; k++) look(32'h300 + 32'(k * 8), 8, 0);
    look(32'h300, 8, 1);
    look(32'h308, 8, 1);
    look(32'h320, 8, 1);

    // Flush with concurrent allocation and update on a full table
    cyc(1, 32'h400, -16, 1, 0, 1, 32'h310, 1, 1, 1, 0);
    look(32'h310, 8, 1);
    look(32'h400, -16, 1);

    // hold_i blocks allocation and counting but not the update
    look(32'h500, 24, 0);
    cyc(1, 32'h600, -4, 1, 1, 1, 32'h500, 1, 0, 0, 0);
    look(32'h600, -4, 1);
    look(32'h500, 24, 1);

    // Mispredict counter saturation on the 2-bit instance, then reset mid-run
    for (int k = 0; k < 5; k++) upd(32'h500, 0, 1);
    upd(32'h900, 1, 1);
    do_reset();
    cyc(0, 32'h80, -32, 1, 0, 0, '0, 0, 0, 0, 0);
    look(32'h500, 24, 1);

    // Randomized traffic over a small PC pool so hits, evictions and races recur
    for (int n = 0; n < 500; n++) begin
      cyc(($urandom_range(0, 9) < 8), pool[$urandom_range(0, 11)],
          (int'($urandom_range(0, 4095)) - 2048) * 2, ($urandom_range(0, 9) < 8),
          ($urandom_range(0, 9) < 2), $urandom_range(0, 1), pool[$urandom_range(0, 11)],
          $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 199) == 0));
    end

    @(negedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predict_table.md
BRANCH_PREDICT_TABLE -- requirements
Module: branch_predict_table

Interface
REQ-001 Parameter ADDR_W, default 32, instruction address width.
REQ-002 Parameter ENTRIES, default 4, table depth; power of two, 2..64.
REQ-003 Parameter CTR_W, default 2, saturating counter width (>=2).
REQ-004 Parameter STAT_W, default 16, statistics counter width.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 lookup_valid_i  in  1  fetch slot valid.
REQ-008 lookup_pc_i  in  ADDR_W  address of fetched instruction.
REQ-009 lookup_inst_i  in  32  fetched instruction word.
REQ-010 hold_i  in  1  fetch stalled.
REQ-011 update_valid_i  in  1  EX resolved a conditional branch.
REQ-012 update_pc_i  in  ADDR_W  address of resolved branch.
REQ-013 update_taken_i  in  1  resolved direction.
REQ-014 update_mispredict_i  in  1  resolved direction differed from prediction.
REQ-015 flush_i  in  1  interrupt/exception; invalidate table.
REQ-016 predict_hit_o  out  1  lookup matched a valid entry.
REQ-017 predict_taken_o  out  1  predict branch taken.
REQ-018 predict_target_o  out  ADDR_W  taken-path target.
REQ-019 lookup_cnt_o  out  STAT_W  branch lookups counted.
REQ-020 mispredict_cnt_o  out  STAT_W  mispredicts counted.

Function
REQ-021 Each entry SHALL hold valid bit, full-width tag (PC), CTR_W-bit counter; MSB=1 means taken.
REQ-022 is_branch SHALL be lookup_inst_i[6:0]==7'b1100011; imm_b = sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],0}.
REQ-023 predict_target_o SHALL be lookup_pc_i+imm_b modulo 2^ADDR_W, combinational, always driven.
REQ-024 Hit SHALL be valid && tag==lookup_pc_i, combinational; at most one entry matches at any time.
REQ-025 predict_taken_o SHALL be lookup_valid_i & is_branch & ~flush_i & (hit ? ctr MSB : imm_b sign bit) -- static backward-taken on miss.
REQ-026 predict_hit_o SHALL be lookup_valid_i & is_branch & hit & ~flush_i.
REQ-027 Allocation SHALL occur when lookup_valid_i & is_branch & ~hit & ~hold_i & ~flush_i: victim = lowest-index invalid entry, else entry at round-robin pointer.
REQ-028 Allocated entry SHALL get tag=lookup_pc_i, valid=1, counter = 10..0 (weak taken) if imm_b<0 else 01..1 (weak not-taken).
REQ-029 Round-robin pointer SHALL advance by 1 mod ENTRIES only when a valid victim is replaced.
REQ-030 Update SHALL apply when update_valid_i & ~flush_i & update_pc_i hits: counter +1 if taken, -1 if not, saturating at all-ones/zero; update miss ignored.
REQ-031 Update is applied regardless of hold_i.
REQ-032 Allocation and update to same entry in one cycle: allocation wins, update dropped.
REQ-033 Lookup SHALL observe pre-edge table state; same-cycle update visible next cycle.
REQ-034 flush_i SHALL clear all valid bits and the pointer next edge, override allocation/update, leave statistics unchanged.
REQ-035 lookup_cnt_o SHALL increment on lookup_valid_i & is_branch & ~hold_i & ~flush_i; saturates at all-ones.
REQ-036 mispredict_cnt_o SHALL increment on update_valid_i & update_mispredict_i & ~flush_i; saturates.

Reset
REQ-037 On rst: all valid=0, counters=01..1, tags=0, pointer=0, both statistics=0; rst overrides every other input.
REQ-038 After reset with no lookup active, predict_hit_o=0, predict_taken_o=0.

Verification
REQ-039 Reset, lookup pc=0x100 backward BEQ imm=-8 -> hit=0, taken=1, target=0xF8; next cycle same lookup hit=1, taken=1, lookup_cnt=1.
REQ-040 Forward branch pc=0x200 imm=+16 allocated, then 2 updates taken=1 -> counter 01->10->11, predict_taken=1; 4 updates taken=0 -> counter 00, saturates, predict_taken=0.
REQ-041 ENTRIES=4: allocate 5 distinct branches -> 5th replaces entry 0, pointer=1; first PC then misses.
REQ-042 Table full, flush_i with concurrent allocation and update -> all valid=0, no allocation, statistics unchanged.
REQ-043 hold_i=1 with missing branch -> no allocation, lookup_cnt unchanged, concurrent hit update still applied.
REQ-044 STAT_W=2, 5 mispredict updates -> mispredict_cnt_o=3; rst mid-run -> all state as REQ-037.
